// File: rtl/abs_pkg.sv
// Shared definitions for the ABS brake-valve sequencer: state encoding and default tuning constants.
package abs_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      APPLY   = 2'd1,
      RELEASE = 2'd2,
      HOLD    = 2'd3
   } abs_state_t;

   localparam int ABS_SLIP_PCT    = 20;
   localparam int ABS_MIN_SPEED   = 5;
   localparam int ABS_RELEASE_CYC = 4;
   localparam int ABS_HOLD_CYC    = 3;

   function automatic int absMax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/abs_slip_detector.sv
// Combinational wheel-lock detector: slip when the wheel trails the vehicle by at least SLIP_PCT percent.
module abs_slip_detector #(
   parameter int SLIP_PCT = abs_pkg::ABS_SLIP_PCT
) (
   input  logic [7:0] wheel_speed,
   input  logic [7:0] vehicle_speed,
   output logic       slip
);

   logic [7:0]  w_diff;
   logic [14:0] w_diffScaled;
   logic [14:0] w_refScaled;

   // Cross-multiplied percentage compare keeps it division-free; 255*100 still fits in 15 bits.
   assign w_diff       = vehicle_speed - wheel_speed;
   assign w_diffScaled = {7'd0, w_diff} * 15'd100;
   assign w_refScaled  = {7'd0, vehicle_speed} * 15'(SLIP_PCT);

   assign slip = (vehicle_speed > wheel_speed) && (w_diffScaled >= w_refScaled);

endmodule

// File: rtl/abs_modulation_sequencer.sv
// ABS valve sequencer: arbitrates brake requests against wheel slip and cycles APPLY/RELEASE/HOLD.
module abs_modulation_sequencer
   import abs_pkg::*;
#(
   parameter int SLIP_PCT    = ABS_SLIP_PCT,
   parameter int MIN_SPEED   = ABS_MIN_SPEED,
   parameter int RELEASE_CYC = ABS_RELEASE_CYC,
   parameter int HOLD_CYC    = ABS_HOLD_CYC
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       brake_pedal,
   input  logic       Object_detected,
   input  logic [7:0] wheel_speed,
   input  logic [7:0] vehicle_speed,
   output logic       brake_signal,
   output logic       release_valve,
   output logic       abs_active,
   output logic [7:0] mod_count
);

   localparam int CNT_W = $clog2(absMax(RELEASE_CYC, HOLD_CYC)) + 1;
   localparam logic [CNT_W-1:0] REL_LOAD  = CNT_W'(RELEASE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
   localparam logic [7:0]       MIN_SPD_V = 8'(MIN_SPEED);

   abs_state_t       r_state;
   abs_state_t       w_nextState;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_nextCnt;
   logic [7:0]       r_modCount;
   logic [7:0]       w_nextModCount;
   logic [7:0]       w_modCountInc;
   logic             w_req;
   logic             w_slip;
   logic             w_modOk;
   logic             w_startRelease;

   abs_slip_detector #(
      .SLIP_PCT(SLIP_PCT)
   ) u_slip (
      .wheel_speed  (wheel_speed),
      .vehicle_speed(vehicle_speed),
      .slip         (w_slip)
   );

   assign w_req          = brake_pedal | Object_detected;
   assign w_modOk        = vehicle_speed > MIN_SPD_V;
   assign w_startRelease = w_slip & w_modOk;
   assign w_modCountInc  = (r_modCount == 8'hFF) ? r_modCount : r_modCount + 8'd1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_modCount <= '0;
      end else begin
         r_state    <= w_nextState;
         r_cnt      <= w_nextCnt;
         r_modCount <= w_nextModCount;
      end
   end

   // Dropping the request overrides every phase, so that check sits ahead of the state decode.
   always_comb begin
      w_nextState    = r_state;
      w_nextCnt      = r_cnt;
      w_nextModCount = r_modCount;
      if (!w_req) begin
         w_nextState = IDLE;
         w_nextCnt   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               w_nextState    = APPLY;
               w_nextModCount = '0;
            end
            APPLY: begin
               if (w_startRelease) begin
                  w_nextState    = RELEASE;
                  w_nextCnt      = REL_LOAD;
                  w_nextModCount = w_modCountInc;
               end
            end
            RELEASE: begin
               if (r_cnt != '0) begin
                  w_nextCnt = r_cnt - 1'b1;
               end else begin
                  w_nextState = HOLD;
                  w_nextCnt   = HOLD_LOAD;
               end
            end
            HOLD: begin
               if (r_cnt != '0) begin
                  w_nextCnt = r_cnt - 1'b1;
               end else if (w_startRelease) begin
                  w_nextState    = RELEASE;
                  w_nextCnt      = REL_LOAD;
                  w_nextModCount = w_modCountInc;
               end else begin
                  w_nextState = APPLY;
               end
            end
            default: begin
               w_nextState = IDLE;
               w_nextCnt   = '0;
            end
         endcase
      end
   end

   assign brake_signal  = (r_state == APPLY);
   assign release_valve = (r_state == RELEASE);
   assign abs_active    = (r_state == RELEASE) || (r_state == HOLD);
   assign mod_count     = r_modCount;

   // Apply and dump valves fighting each other would vent the circuit.
   assert property (@(posedge clk) disable iff (!rst) !(brake_signal && release_valve));

endmodule
